// File: rtl/fetch_sequencer.sv
// fetch_sequencer
//   Owns the fetch PC and drives the instruction-memory request port.
//   Arbitrates halt > redirect > stall > imem_ready each cycle while running
//   and produces a one-cycle flush bubble after every redirect.
//
// Ports
//   clk, rst            clock (rising edge), asynchronous active-low reset
//   start               leave IDLE/HALTED, begin fetching at RESET_ADDR
//   halt                decode saw the halt opcode
//   redirect            taken branch/jump, target on redirect_addr
//   stall               hazard unit holds fetch
//   imem_ready          instruction memory accepts the current request
//   imem_req/imem_addr  fetch request and its address (the PC)
//   fetch_valid         pulse: a fetch was accepted the previous cycle
//   fetch_pc            address of the last accepted fetch
//   flush               kill younger stages (high in REDIRECT)
//   halted, busy        status decoded from state
//   redirect_count      redirects acted on (saturating)
//
// Build option
//   REDIRECT_COUNT_EN   when defined, redirect_count is a live saturating
//                       counter; otherwise it is tied to zero.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// IDLE     | out of reset, pc at RESET_ADDR, waiting for start
// FETCH    | request asserted at pc, advances on accepted fetch
// STALL    | request withdrawn while the hazard unit holds fetch
// REDIRECT | one-cycle bubble after a taken branch, flush asserted
// HALTED   | halt seen, pc frozen, waiting for start

module fetch_sequencer #(
    parameter int               WIDTH      = 32,
    parameter logic [WIDTH-1:0] RESET_ADDR = '0,
    parameter logic [WIDTH-1:0] STEP       = WIDTH'(4)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             halt,
    input  logic             redirect,
    input  logic [WIDTH-1:0] redirect_addr,
    input  logic             stall,
    input  logic             imem_ready,
    output logic             imem_req,
    output logic [WIDTH-1:0] imem_addr,
    output logic             fetch_valid,
    output logic [WIDTH-1:0] fetch_pc,
    output logic             flush,
    output logic             halted,
    output logic             busy,
    output logic [15:0]      redirect_count
);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_FETCH    = 3'd1,
        S_STALL    = 3'd2,
        S_REDIRECT = 3'd3,
        S_HALTED   = 3'd4
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] pc;
    logic [WIDTH-1:0] pc_next;
    logic             accept;
    logic [WIDTH-1:0] target;

    // Instructions are word aligned; the low address bits are dropped.
    assign target = {redirect_addr[WIDTH-1:2], 2'b00};

    logic unused_addr_bits;
    assign unused_addr_bits = ^redirect_addr[1:0];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        pc_next    = pc;
        accept     = 1'b0;
        imem_req   = 1'b0;
        flush      = 1'b0;
        halted     = 1'b0;
        busy       = 1'b0;
        case (state)
            S_IDLE, S_HALTED: begin
                halted = (state == S_HALTED);
                if (start) begin
                    state_next = S_FETCH;
                    pc_next    = RESET_ADDR;
                end
            end
            default: begin
                busy     = 1'b1;
                imem_req = (state == S_FETCH);
                flush    = (state == S_REDIRECT);
                if (halt) begin
                    state_next = S_HALTED;
                end else if (redirect) begin
                    state_next = S_REDIRECT;
                    pc_next    = target;
                end else begin
                    case (state)
                        S_FETCH: begin
                            if (stall) begin
                                state_next = S_STALL;
                            end else if (imem_ready) begin
                                accept  = 1'b1;
                                pc_next = pc + STEP;
                            end
                        end
                        S_STALL: begin
                            if (!stall) begin
                                state_next = S_FETCH;
                            end
                        end
                        // REDIRECT bubble always lasts one cycle; stall is ignored here.
                        default: state_next = S_FETCH;
                    endcase
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc          <= RESET_ADDR;
            fetch_pc    <= '0;
            fetch_valid <= 1'b0;
        end else begin
            pc          <= pc_next;
            fetch_valid <= accept;
            if (accept) begin
                fetch_pc <= pc;
            end
        end
    end

    assign imem_addr = pc;

`ifdef REDIRECT_COUNT_EN
    logic        redirect_take;
    logic [15:0] redirect_count_q;

    // A redirect counts only when it is acted on: running and not overridden by halt.
    assign redirect_take = redirect && !halt &&
                           (state == S_FETCH || state == S_STALL || state == S_REDIRECT);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            redirect_count_q <= 16'h0000;
        end else if (redirect_take && (redirect_count_q != 16'hFFFF)) begin
            redirect_count_q <= redirect_count_q + 16'd1;
        end
    end

    assign redirect_count = redirect_count_q;
`else
    assign redirect_count = 16'h0000;
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
module tb_fetch_sequencer;

    localparam logic [31:0] RA = 32'h0000_0000;

    localparam int M_IDLE   = 0;
    localparam int M_RUN    = 1;
    localparam int M_HOLD   = 2;
    localparam int M_BUBBLE = 3;
    localparam int M_STOP   = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        start, halt, redirect, stall, imem_ready;
    logic [31:0] redirect_addr;
    logic        imem_req, fetch_valid, flush, halted, busy;
    logic [31:0] imem_addr, fetch_pc;
    logic [15:0] redirect_count;

    int total = 0;
    int bad   = 0;

    // behavioural reference
    int          m_mode;
    logic [31:0] m_pc;
    logic [31:0] m_fpc;
    logic        m_fv;
    int          m_cnt;

    fetch_sequencer dut (
        .clk(clk), .rst(rst), .start(start), .halt(halt), .redirect(redirect),
        .redirect_addr(redirect_addr), .stall(stall), .imem_ready(imem_ready),
        .imem_req(imem_req), .imem_addr(imem_addr), .fetch_valid(fetch_valid),
        .fetch_pc(fetch_pc), .flush(flush), .halted(halted), .busy(busy),
        .redirect_count(redirect_count)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        m_mode = M_IDLE;
        m_pc   = RA;
        m_fpc  = 32'h0;
        m_fv   = 1'b0;
        m_cnt  = 0;
    endtask

    task automatic model_step();
        m_fv = 1'b0;
        if (m_mode == M_IDLE || m_mode == M_STOP) begin
            if (start) begin
                m_mode = M_RUN;
                m_pc   = RA;
            end
        end else if (halt) begin
            m_mode = M_STOP;
        end else if (redirect) begin
            m_mode = M_BUBBLE;
            m_pc   = redirect_addr & 32'hFFFF_FFFC;
`ifdef REDIRECT_COUNT_EN
            if (m_cnt < 65535) m_cnt = m_cnt + 1;
`endif
        end else if (m_mode == M_RUN) begin
            if (stall) m_mode = M_HOLD;
            else if (imem_ready) begin
                m_fpc = m_pc;
                m_pc  = m_pc + 32'd4;
                m_fv  = 1'b1;
            end
        end else if (m_mode == M_HOLD) begin
            if (!stall) m_mode = M_RUN;
        end else begin
            m_mode = M_RUN;
        end
    endtask

    task automatic cycle(input logic s, input logic h, input logic r, input logic [31:0] ra,
                         input logic st, input logic rdy);
        start = s; halt = h; redirect = r; redirect_addr = ra; stall = st; imem_ready = rdy;
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        start = 0; halt = 0; redirect = 0; redirect_addr = 0; stall = 0; imem_ready = 0;
        model_reset();
        #2;
        total++;
        if ({imem_req, fetch_valid, flush, halted, busy} !== 5'b0 || imem_addr !== RA ||
            fetch_pc !== 32'h0 || redirect_count !== 16'h0) begin
            bad++;
            $display("FAIL reset_state: got req=%b fv=%b fl=%b h=%b b=%b addr=%h fpc=%h cnt=%h, want all zero",
                     imem_req, fetch_valid, flush, halted, busy, imem_addr, fetch_pc, redirect_count);
        end
        @(posedge clk); #1;
        rst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            cycle(0, 1'($urandom), 1'($urandom), $urandom, 1'($urandom), 1'($urandom));
            total++;
            if (imem_req !== 1'b0 || busy !== 1'b0 || imem_addr !== RA) begin
                bad++;
                $display("FAIL idle_ignores: got req=%b busy=%b addr=%h, want 0 0 %h", imem_req, busy, imem_addr, RA);
            end
        end
    endtask

    task automatic test_sequential();
        cycle(1, 0, 0, 0, 0, 0);
        total++;
        if (imem_req !== 1'b1 || imem_addr !== RA) begin
            bad++;
            $display("FAIL start_latency: got req=%b addr=%h, want 1 %h", imem_req, imem_addr, RA);
        end
        for (int i = 0; i < 4; i++) begin
            total++;
            if (imem_addr !== 32'(4 * i)) begin
                bad++;
                $display("FAIL seq_addr: got %h want %h", imem_addr, 32'(4 * i));
            end
            cycle(0, 0, 0, 0, 0, 1);
            total++;
            if (fetch_valid !== 1'b1 || fetch_pc !== 32'(4 * i)) begin
                bad++;
                $display("FAIL seq_fetch: got fv=%b fpc=%h want 1 %h", fetch_valid, fetch_pc, 32'(4 * i));
            end
        end
        cycle(0, 0, 0, 0, 0, 0);
        total++;
        if (fetch_valid !== 1'b0 || imem_addr !== 32'd16 || imem_req !== 1'b1) begin
            bad++;
            $display("FAIL seq_idle_hold: got fv=%b addr=%h req=%b want 0 10 1", fetch_valid, imem_addr, imem_req);
        end
    endtask

    task automatic test_redirect();
        logic [15:0] want_cnt;
`ifdef REDIRECT_COUNT_EN
        want_cnt = 16'd1;
`else
        want_cnt = 16'd0;
`endif
        cycle(0, 0, 1, 32'h0000_0043, 0, 1);
        total++;
        if (flush !== 1'b1 || imem_req !== 1'b0 || fetch_valid !== 1'b0 || redirect_count !== want_cnt) begin
            bad++;
            $display("FAIL redirect_bubble: got flush=%b req=%b fv=%b cnt=%h want 1 0 0 %h",
                     flush, imem_req, fetch_valid, redirect_count, want_cnt);
        end
        cycle(0, 0, 0, 0, 1, 0);
        total++;
        if (imem_addr !== 32'h40 || imem_req !== 1'b1 || flush !== 1'b0) begin
            bad++;
            $display("FAIL redirect_target: got addr=%h req=%b flush=%b want 40 1 0", imem_addr, imem_req, flush);
        end
    endtask

    task automatic test_priority();
        logic [15:0] cnt_before;
        cnt_before = redirect_count;
        cycle(0, 1, 1, 32'h0000_1234, 1, 1);
        total++;
        if (halted !== 1'b1 || imem_addr !== 32'h40 || flush !== 1'b0 || imem_req !== 1'b0 ||
            busy !== 1'b0 || redirect_count !== cnt_before) begin
            bad++;
            $display("FAIL halt_priority: got h=%b addr=%h fl=%b req=%b busy=%b cnt=%h want 1 40 0 0 0 %h",
                     halted, imem_addr, flush, imem_req, busy, redirect_count, cnt_before);
        end
        cycle(0, 0, 1, 32'h0000_0100, 0, 1);
        total++;
        if (halted !== 1'b1 || imem_addr !== 32'h40) begin
            bad++;
            $display("FAIL halted_frozen: got h=%b addr=%h want 1 40", halted, imem_addr);
        end
        cycle(1, 0, 0, 0, 0, 0);
        total++;
        if (imem_addr !== RA || imem_req !== 1'b1 || halted !== 1'b0) begin
            bad++;
            $display("FAIL restart: got addr=%h req=%b h=%b want %h 1 0", imem_addr, imem_req, halted, RA);
        end
    endtask

    task automatic test_stall();
        cycle(0, 0, 1, 32'h0000_0020, 0, 0);
        cycle(0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            cycle(0, 0, 0, 0, 1, 1);
            total++;
            if (imem_req !== 1'b0 || fetch_valid !== 1'b0 || busy !== 1'b1) begin
                bad++;
                $display("FAIL stall_hold %0d: got req=%b fv=%b busy=%b want 0 0 1", i, imem_req, fetch_valid, busy);
            end
        end
        cycle(0, 0, 0, 0, 0, 0);
        total++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h20 || fetch_valid !== 1'b0) begin
            bad++;
            $display("FAIL stall_release: got req=%b addr=%h fv=%b want 1 20 0", imem_req, imem_addr, fetch_valid);
        end
    endtask

    task automatic test_wrap();
        cycle(0, 0, 1, 32'hFFFF_FFFE, 0, 0);
        cycle(0, 0, 0, 0, 0, 0);
        total++;
        if (imem_addr !== 32'hFFFF_FFFC) begin
            bad++;
            $display("FAIL wrap_setup: got %h want fffffffc", imem_addr);
        end
        cycle(0, 0, 0, 0, 0, 1);
        total++;
        if (fetch_valid !== 1'b1 || fetch_pc !== 32'hFFFF_FFFC || imem_addr !== 32'h0) begin
            bad++;
            $display("FAIL wrap: got fv=%b fpc=%h addr=%h want 1 fffffffc 0", fetch_valid, fetch_pc, imem_addr);
        end
    endtask

    task automatic test_random();
        int errs;
        logic s, h, r, st, rdy;
        errs = 0;
        for (int i = 0; i < 600; i++) begin
            s   = ($urandom_range(7) == 0);
            h   = ($urandom_range(23) == 0);
            r   = ($urandom_range(7) == 0);
            st  = ($urandom_range(3) == 0);
            rdy = ($urandom_range(1) == 0);
            cycle(s, h, r, $urandom, st, rdy);
            total++;
            if (imem_req !== (m_mode == M_RUN) || imem_addr !== m_pc || fetch_valid !== m_fv ||
                fetch_pc !== m_fpc || flush !== (m_mode == M_BUBBLE) || halted !== (m_mode == M_STOP) ||
                busy !== (m_mode == M_RUN || m_mode == M_HOLD || m_mode == M_BUBBLE) ||
                redirect_count !== 16'(m_cnt)) begin
                bad++;
                errs++;
                if (errs < 10)
                    $display("FAIL random cycle %0d: got req=%b addr=%h fv=%b fpc=%h fl=%b h=%b b=%b cnt=%h; want mode=%0d addr=%h fv=%b fpc=%h cnt=%h",
                             i, imem_req, imem_addr, fetch_valid, fetch_pc, flush, halted, busy, redirect_count,
                             m_mode, m_pc, m_fv, m_fpc, 16'(m_cnt));
            end
        end
    endtask

    task automatic test_back_to_back();
        cycle(1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 6; i++) begin
            cycle(0, 0, 0, 0, 0, 1);
            total++;
            if (fetch_valid !== 1'b1 || fetch_pc !== m_fpc || imem_addr !== m_pc) begin
                bad++;
                $display("FAIL back_to_back %0d: got fv=%b fpc=%h addr=%h want 1 %h %h",
                         i, fetch_valid, fetch_pc, imem_addr, m_fpc, m_pc);
            end
        end
    endtask

    task automatic test_reset_mid();
        cycle(1, 0, 0, 0, 0, 0);
        imem_ready = 1'b1;
        #3;
        rst = 1'b0;
        #1;
        total++;
        if (imem_req !== 1'b0 || busy !== 1'b0 || fetch_valid !== 1'b0 || imem_addr !== RA ||
            flush !== 1'b0 || redirect_count !== 16'h0) begin
            bad++;
            $display("FAIL reset_mid: got req=%b busy=%b fv=%b addr=%h fl=%b cnt=%h want 0 0 0 %h 0 0",
                     imem_req, busy, fetch_valid, imem_addr, flush, redirect_count, RA);
        end
        @(posedge clk); #1;
        model_reset();
        rst = 1'b1;
        cycle(0, 0, 0, 0, 0, 1);
        total++;
        if (fetch_valid !== 1'b0 || imem_req !== 1'b0 || flush !== 1'b0) begin
            bad++;
            $display("FAIL reset_release: got fv=%b req=%b fl=%b want 0 0 0", fetch_valid, imem_req, flush);
        end
    endtask

    task automatic test_counter();
        cycle(1, 0, 0, 0, 0, 0);
`ifdef REDIRECT_COUNT_EN
        for (int i = 0; i < 70000; i++) cycle(0, 0, 1, 32'(i * 4), 0, 0);
        total++;
        if (redirect_count !== 16'hFFFF) begin
            bad++;
            $display("FAIL count_saturate: got %h want ffff", redirect_count);
        end
`else
        for (int i = 0; i < 40; i++) cycle(0, 0, 1, 32'(i * 4), 0, 0);
        total++;
        if (redirect_count !== 16'h0000) begin
            bad++;
            $display("FAIL count_disabled: got %h want 0000", redirect_count);
        end
`endif
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_redirect();
        test_priority();
        test_stall();
        test_wrap();
        test_back_to_back();
        test_random();
        test_reset_mid();
        test_counter();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
